// File: rtl/calc_pkg.sv
// calc_pkg: shared op encodings, FSM states and defaults for the calculator sequencer.
package calc_pkg;
   localparam int DW = 16;
   localparam int RW = 32;
   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;
   localparam logic [RW-1:0] DIV0_RESULT = '1;
   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;
endpackage

// File: rtl/calc_cmd_buf.sv
// calc_cmd_buf: 2-entry command buffer (executing cmd slot + pend slot) with sticky overflow.
module calc_cmd_buf #(
   parameter int W = 35
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         cmd_v,
   output logic         pend_v,
   output logic         ovf
);
   logic [W-1:0] pend;
   logic         cv1, pv1;
   // Pop is applied first so a same-cycle push lands in the freed slot.
   assign cv1 = pop ? pend_v : cmd_v;
   assign pv1 = pop ? 1'b0 : pend_v;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout   <= '0;
         pend   <= '0;
         cmd_v  <= 1'b0;
         pend_v <= 1'b0;
         ovf    <= 1'b0;
      end else begin
         cmd_v  <= cv1 | push;
         pend_v <= pv1 | (push & cv1);
         dout   <= (push && !cv1) ? din : pop ? pend : dout;
         pend   <= (push && cv1 && !pv1) ? din : pend;
         ovf    <= ovf | (push & cv1 & pv1);
      end
   end
endmodule

// File: rtl/calc_seq.sv
// calc_seq: sequences parsed commands onto the shared ALU and hands results out via valid/ready.
// Optional ALU watchdog enabled by defining CALC_SEQ_TIMEOUT_EN (adds err_tmo).
module calc_seq
   import calc_pkg::*;
#(
   parameter int DW          = calc_pkg::DW,
   parameter int RW          = calc_pkg::RW,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          parser_done,
   input  logic [DW-1:0] a,
   input  logic [DW-1:0] b,
   input  logic [1:0]    op,
   input  logic          data_type,
   output logic [DW-1:0] alu_a,
   output logic [DW-1:0] alu_b,
   output logic [1:0]    alu_op,
   output logic          alu_start,
   input  logic [RW-1:0] alu_result,
   input  logic          alu_done,
   output logic [RW-1:0] result,
   output logic          result_valid,
   input  logic          result_ready,
   output logic          err_div0,
`ifdef CALC_SEQ_TIMEOUT_EN
   output logic          err_tmo,
`endif
   output logic          err_ovf,
   output logic          busy
);
   localparam int CW = 2*DW + 3;
   state_e        state;
   logic [CW-1:0] cmd;
   logic          cmd_v, pend_v, pop;
   logic [DW-1:0] c_a, c_b, acc;
   logic [1:0]    c_op;
   logic          c_dt;
`ifdef CALC_SEQ_TIMEOUT_EN
   logic [$clog2(TIMEOUT_CYC+1)-1:0] cnt;
`endif
   assign {c_a, c_b, c_op, c_dt} = cmd;
   assign pop  = state == HOLD && result_valid && result_ready;
   assign busy = state != IDLE || cmd_v;
   calc_cmd_buf #(.W(CW)) u_buf (
      .clk    (clk),
      .rst_n  (rst_n),
      .push   (parser_done),
      .din    ({a, b, op, data_type}),
      .pop    (pop),
      .dout   (cmd),
      .cmd_v  (cmd_v),
      .pend_v (pend_v),
      .ovf    (err_ovf)
   );
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         alu_a        <= '0;
         alu_b        <= '0;
         alu_op       <= '0;
         alu_start    <= 1'b0;
         result       <= '0;
         result_valid <= 1'b0;
         err_div0     <= 1'b0;
         acc          <= '0;
`ifdef CALC_SEQ_TIMEOUT_EN
         err_tmo      <= 1'b0;
         cnt          <= '0;
`endif
      end else begin
         case (state)
            IDLE: if (cmd_v) state <= ISSUE;
            ISSUE: begin
               if (c_op == OP_DIV && c_b == '0) begin
                  result       <= DIV0_RESULT;
                  err_div0     <= 1'b1;
                  result_valid <= 1'b1;
`ifdef CALC_SEQ_TIMEOUT_EN
                  err_tmo      <= 1'b0;
`endif
                  state        <= HOLD;
               end else begin
                  alu_a     <= c_dt ? acc : c_a;
                  alu_b     <= c_b;
                  alu_op    <= c_op;
                  alu_start <= 1'b1;
`ifdef CALC_SEQ_TIMEOUT_EN
                  cnt       <= '0;
`endif
                  state     <= WAIT;
               end
            end
            WAIT: begin
               if (alu_done) begin
                  alu_start    <= 1'b0;
                  result       <= alu_result;
                  err_div0     <= 1'b0;
                  acc          <= alu_result[DW-1:0];
                  result_valid <= 1'b1;
`ifdef CALC_SEQ_TIMEOUT_EN
                  err_tmo      <= 1'b0;
`endif
                  state        <= HOLD;
               end
`ifdef CALC_SEQ_TIMEOUT_EN
               else if (cnt == $bits(cnt)'(TIMEOUT_CYC - 1)) begin
                  alu_start    <= 1'b0;
                  result       <= '0;
                  err_div0     <= 1'b0;
                  err_tmo      <= 1'b1;
                  result_valid <= 1'b1;
                  state        <= HOLD;
               end else cnt <= cnt + 1'b1;
`endif
            end
            HOLD: if (pop) begin
               result_valid <= 1'b0;
               // A same-cycle parser_done refills the freed slot, so it counts as remaining work.
               state        <= (pend_v || parser_done) ? ISSUE : IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_calc_seq.sv
// tb_calc_seq: randomized self-checking bench for calc_seq with a stub ALU and a command-level reference model.
module tb_calc_seq;
   logic        clk = 0, rst_n = 0, parser_done = 0, data_type = 0, result_ready = 1;
   logic [15:0] a = 0, b = 0, alu_a, alu_b;
   logic [1:0]  op = 0, alu_op;
   logic        alu_start, alu_done, result_valid, err_div0, err_ovf, busy;
   logic [31:0] alu_result, result;
`ifdef CALC_SEQ_TIMEOUT_EN
   logic        err_tmo;
`endif
   int          tests = 0, fails = 0, lat = 0, lat_cnt = 0, n_start = 0;
   logic        alu_hang = 0;
   logic [15:0] m_acc = 0;
   logic [32:0] exp_q[$];

   always #5 clk = ~clk;

   calc_seq dut (
      .clk(clk), .rst_n(rst_n), .parser_done(parser_done), .a(a), .b(b), .op(op),
      .data_type(data_type), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
      .alu_start(alu_start), .alu_result(alu_result), .alu_done(alu_done),
      .result(result), .result_valid(result_valid), .result_ready(result_ready),
      .err_div0(err_div0),
`ifdef CALC_SEQ_TIMEOUT_EN
      .err_tmo(err_tmo),
`endif
      .err_ovf(err_ovf), .busy(busy)
   );

   // Stub ALU: answers after lat cycles of alu_start unless hung.
   always @(posedge clk) begin
      lat_cnt <= alu_start ? lat_cnt + 1 : 0;
      if (alu_start) n_start <= n_start + 1;
   end
   assign alu_done = alu_start && !alu_hang && lat_cnt >= lat;
   always_comb begin
      case (alu_op)
         2'b00:   alu_result = {16'd0, alu_a} + {16'd0, alu_b};
         2'b01:   alu_result = {16'd0, alu_a} - {16'd0, alu_b};
         2'b10:   alu_result = {16'd0, alu_a} * {16'd0, alu_b};
         default: alu_result = (alu_b == 0) ? 32'hFFFF_FFFF : {16'd0, alu_a / alu_b};
      endcase
   end

   // Reference: {div0, result} of one command, tracking the chained accumulator.
   function automatic logic [32:0] model(input logic [15:0] ia, ib, input logic [1:0] iop, input logic idt);
      logic [31:0] x, y, r;
      x = {16'd0, idt ? m_acc : ia};
      y = {16'd0, ib};
      if (iop == 2'b11 && ib == 0) return {1'b1, 32'hFFFF_FFFF};
      r = iop == 2'b00 ? x + y : iop == 2'b01 ? x - y : iop == 2'b10 ? x * y : x / y;
      m_acc = r[15:0];
      return {1'b0, r};
   endfunction

   task automatic push(input logic [15:0] ia, ib, input logic [1:0] iop, input logic idt);
      a = ia; b = ib; op = iop; data_type = idt; parser_done = 1;
   endtask

   task automatic send(input logic [15:0] ia, ib, input logic [1:0] iop, input logic idt);
      @(negedge clk);
      push(ia, ib, iop, idt);
      @(negedge clk);
      parser_done = 0;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      while (!result_valid && n < 60) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset;
      repeat (2) @(negedge clk);
      tests++;
      if ({result_valid, alu_start, err_div0, err_ovf, busy} !== 5'b0 || result !== 0) begin
         fails++;
         $display("FAIL reset_hold: flags=%b result=%h required 0", {result_valid, alu_start, err_div0, err_ovf, busy}, result);
      end
      rst_n = 1;
      @(negedge clk);
      tests++;
      if (busy !== 0 || result_valid !== 0) begin
         fails++;
         $display("FAIL reset_release: busy=%b valid=%b required 0", busy, result_valid);
      end
   endtask

   task automatic test_basic;
      int n;
      logic [32:0] e;
      lat = 0;
      e = model(7, 5, 2'b00, 0);
      send(7, 5, 2'b00, 0);
      wait_valid(n);
      tests++;
      if (n !== 3) begin fails++; $display("FAIL basic_latency: got %0d cycles required 3", n); end
      tests++;
      if (result !== e[31:0] || err_div0 !== e[32]) begin
         fails++;
         $display("FAIL basic_add: result=%0d div0=%b required %0d/%b", result, err_div0, e[31:0], e[32]);
      end
      @(negedge clk);
   endtask

   task automatic test_chain;
      int n;
      logic [32:0] e;
      lat = $urandom_range(0, 3);
      e = model(300, 200, 2'b10, 0);
      send(300, 200, 2'b10, 0);
      wait_valid(n);
      tests++;
      if (result !== e[31:0] || result !== 60000) begin fails++; $display("FAIL chain_mul: result=%0d required 60000", result); end
      @(negedge clk);
      e = model(0, 4, 2'b11, 1);
      send(0, 4, 2'b11, 1);
      wait_valid(n);
      tests++;
      if (result !== e[31:0] || err_div0 !== 0) begin
         fails++;
         $display("FAIL chain_div: result=%0d div0=%b required %0d/0", result, err_div0, e[31:0]);
      end
      @(negedge clk);
   endtask

   task automatic test_div0;
      int n, s;
      logic [32:0] e;
      s = n_start;
      e = model(9, 0, 2'b11, 0);
      send(9, 0, 2'b11, 0);
      wait_valid(n);
      tests++;
      if (result !== e[31:0] || err_div0 !== 1) begin
         fails++;
         $display("FAIL div0_result: result=%h div0=%b required ffffffff/1", result, err_div0);
      end
      tests++;
      if (n_start !== s) begin fails++; $display("FAIL div0_nostart: alu_start cycles=%0d required 0", n_start - s); end
      @(negedge clk);
      e = model(0, 0, 2'b00, 1);
      send(0, 0, 2'b00, 1);
      wait_valid(n);
      tests++;
      if (result !== e[31:0]) begin fails++; $display("FAIL div0_acc_kept: result=%0d required %0d", result, e[31:0]); end
      @(negedge clk);
   endtask

   task automatic test_back_to_back;
      int n;
      logic [15:0] ra, rb;
      logic [1:0] rop;
      logic rdt;
      result_ready = 1;
      for (int k = 0; k < 32; k++) begin
         ra = 16'($urandom);
         rb = ($urandom_range(0, 4) == 0) ? 16'd0 : 16'($urandom);
         rop = 2'($urandom_range(0, 3));
         rdt = 1'($urandom_range(0, 1));
         if (k >= 2) wait_valid(n);
         if (k >= 2) begin
            tests++;
            if (!result_valid || {err_div0, result} !== exp_q[0]) begin
               fails++;
               $display("FAIL b2b_%0d: valid=%b div0=%b result=%h required %b/%h", k - 2, result_valid, err_div0, result, exp_q[0][32], exp_q[0][31:0]);
            end
            void'(exp_q.pop_front());
            lat = $urandom_range(0, 3);
         end
         if (k < 30) begin
            exp_q.push_back(model(ra, rb, rop, rdt));
            if (k < 2) send(ra, rb, rop, rdt);
            else begin
               push(ra, rb, rop, rdt);
               @(negedge clk);
               parser_done = 0;
            end
         end else @(negedge clk);
      end
      tests++;
      if (exp_q.size() !== 0 || err_ovf !== 0) begin
         fails++;
         $display("FAIL b2b_drain: left=%0d ovf=%b required 0/0", exp_q.size(), err_ovf);
      end
   endtask

   task automatic test_overflow;
      int n;
      logic [32:0] e1, e2;
      result_ready = 0;
      lat = 0;
      e1 = model(1, 1, 2'b00, 0);
      e2 = model(2, 2, 2'b00, 0);
      send(1, 1, 2'b00, 0);
      send(2, 2, 2'b00, 0);
      send(3, 3, 2'b00, 0);
      tests++;
      if (err_ovf !== 1) begin fails++; $display("FAIL ovf_flag: err_ovf=%b required 1", err_ovf); end
      wait_valid(n);
      tests++;
      if (result !== e1[31:0]) begin fails++; $display("FAIL ovf_first: result=%0d required %0d", result, e1[31:0]); end
      result_ready = 1;
      @(negedge clk);
      wait_valid(n);
      tests++;
      if (result !== e2[31:0]) begin fails++; $display("FAIL ovf_second: result=%0d required %0d", result, e2[31:0]); end
      n = 0;
      repeat (12) begin
         @(negedge clk);
         if (result_valid) n++;
      end
      tests++;
      if (n !== 0 || busy !== 0 || err_ovf !== 1) begin
         fails++;
         $display("FAIL ovf_lost: extra results=%0d busy=%b ovf=%b required 0/0/1", n, busy, err_ovf);
      end
   endtask

   task automatic test_reset_mid;
      int n;
      logic [32:0] e;
      alu_hang = 1;
      send(1, 2, 2'b00, 0);
      send(3, 4, 2'b00, 0);
      repeat (2) @(negedge clk);
      tests++;
      if (alu_start !== 1) begin fails++; $display("FAIL mid_in_wait: alu_start=%b required 1", alu_start); end
      #2 rst_n = 0;
      #1;
      tests++;
      if ({result_valid, alu_start, err_div0, err_ovf, busy} !== 5'b0 || result !== 0 || alu_a !== 0 || alu_b !== 0) begin
         fails++;
         $display("FAIL mid_reset: flags=%b result=%h alu_a=%h alu_b=%h required 0", {result_valid, alu_start, err_div0, err_ovf, busy}, result, alu_a, alu_b);
      end
      @(negedge clk);
      rst_n = 1;
      alu_hang = 0;
      m_acc = 0;
      repeat (5) @(negedge clk);
      tests++;
      if (busy !== 0 || result_valid !== 0) begin fails++; $display("FAIL mid_discard: busy=%b valid=%b required 0", busy, result_valid); end
      e = model(0, 5, 2'b00, 1);
      send(0, 5, 2'b00, 1);
      wait_valid(n);
      tests++;
      if (result !== e[31:0]) begin fails++; $display("FAIL mid_acc_cleared: result=%0d required %0d", result, e[31:0]); end
      @(negedge clk);
   endtask

`ifdef CALC_SEQ_TIMEOUT_EN
   task automatic test_timeout;
      int n;
      alu_hang = 1;
      result_ready = 0;
      send(1, 1, 2'b00, 0);
      n = 0;
      for (int i = 0; i < 60 && !result_valid; i++) begin
         @(negedge clk);
         if (alu_start) n++;
      end
      tests++;
      if (!result_valid || n !== 15) begin fails++; $display("FAIL tmo_cycles: valid=%b wait=%0d required 1/15", result_valid, n); end
      tests++;
      if (err_tmo !== 1 || result !== 0 || err_div0 !== 0 || alu_start !== 0) begin
         fails++;
         $display("FAIL tmo_result: tmo=%b result=%h div0=%b start=%b required 1/0/0/0", err_tmo, result, err_div0, alu_start);
      end
      result_ready = 1;
      repeat (2) @(negedge clk);
      tests++;
      if (busy !== 0 || result_valid !== 0) begin fails++; $display("FAIL tmo_idle: busy=%b valid=%b required 0", busy, result_valid); end
      alu_hang = 0;
   endtask
`endif

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_basic;
      test_chain;
      test_div0;
      test_back_to_back;
      test_overflow;
      test_reset_mid;
`ifdef CALC_SEQ_TIMEOUT_EN
      test_timeout;
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
